// File: rtl/hilo_muldiv.sv
// MIPS HI/LO multiply/divide unit: 33 cycles start-to-HI/LO; 1 cycle for divide-by-zero and, with FAST_MULT_EN, multiply.
// busy stalls the pipeline from accept through the FIX write; start and MTHI/MTLO are taken only in IDLE.
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_pend_q, dz_pend_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic        a_sgn, b_sgn;
  logic [31:0] a_mag, b_mag;
  logic        div_zero;
  logic [32:0] mul_sum;
  logic [32:0] div_part;
  logic [32:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

`ifdef FAST_MULT_EN
  logic [63:0] a_ext, b_ext, fast_prod;
  always_comb begin
    a_ext     = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
    b_ext     = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
    fast_prod = a_ext * b_ext;
  end
`endif

  // Operands are reduced to magnitudes at accept; signs are reapplied in FIX.
  always_comb begin
    a_sgn    = ~op[0] & a[31];
    b_sgn    = ~op[0] & b[31];
    a_mag    = a_sgn ? (32'd0 - a) : a;
    b_mag    = b_sgn ? (32'd0 - b) : b;
    div_zero = op[1] && (b == 32'd0);
  end

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    div_part = acc_q[63:31];
    div_diff = div_part - {1'b0, opnd_q};
    prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_pend_d = dz_pend_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = dz_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = RUN;
            cnt_d     = 5'd0;
            dz_d      = 1'b0;
            is_div_d  = op[1];
            neg_d     = a_sgn ^ b_sgn;
            neg_rem_d = a_sgn;
            dz_pend_d = div_zero;
            opnd_d    = op[1] ? b_mag : a_mag;
            acc_d     = {32'd0, (op[1] ? a_mag : b_mag)};
            // Divide-by-zero result is preloaded so FIX's divide path writes it unchanged.
            if (div_zero) begin
              state_d   = FIX;
              acc_d     = {a, 32'hFFFF_FFFF};
              neg_d     = 1'b0;
              neg_rem_d = 1'b0;
            end
`ifdef FAST_MULT_EN
            if (!op[1]) begin
              state_d = FIX;
              acc_d   = fast_prod;
              neg_d   = 1'b0;
            end
`endif
          end else begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
          end
        end

        RUN: begin
          if (is_div_q) begin
            if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
            else               acc_d = {div_part[31:0], acc_q[30:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = FIX;
        end

        FIX: begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
          done_d  = 1'b1;
          dz_d    = dz_pend_q;
          state_d = IDLE;
          cnt_d   = 5'd0;
        end

        default: begin
          state_d = IDLE;
          cnt_d   = 5'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy = (start && (state_q == IDLE)) || (state_q != IDLE);
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized and directed bench for hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush, hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // MIPS HI/LO semantics from plain integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint      sa, sb, sp, q, r;
    logic [63:0] up;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    ed = 1'b0;
    case (o)
      2'd0: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
      2'd1: begin up = {32'd0, x} * {32'd0, y}; eh = up[63:32]; el = up[31:0]; end
      default: begin
        if (y == 32'd0) begin
          eh = x; el = 32'hFFFF_FFFF; ed = 1'b1;
        end else if (o == 2'd2) begin
          q = sa / sb; r = sa % sb;
          eh = r[31:0]; el = q[31:0];
        end else begin
          eh = x % y; el = x / y;
        end
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] y);
    if (o[1] && y == 32'd0) return 1;
`ifdef FAST_MULT_EN
    if (!o[1]) return 1;
`endif
    return 33;
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_cmd(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    logic        ed;
    int          n;
    bit          busy_ok;
    model(o, x, y, eh, el, ed);
    start = 1'b1; op = o; a = x; b = y;
    #1 check_eq($sformatf("busy_e0 op%0d", o), busy, 1);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("latency op%0d %h/%h", o, x, y), n, exp_latency(o, y));
    check_eq($sformatf("busy_run op%0d", o), busy_ok, 1);
    check_eq($sformatf("busy_done op%0d", o), busy, 0);
    check_eq($sformatf("hi op%0d %h,%h", o, x, y), hi, eh);
    check_eq($sformatf("lo op%0d %h,%h", o, x, y), lo, el);
    check_eq($sformatf("dz op%0d", o), dz, ed);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n, m;
    bit          seen;
    logic [31:0] eh, el;
    logic        ed;

    rst = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("reset hi", hi, 0);
    check_eq("reset lo", lo, 0);
    check_eq("reset busy", busy, 0);
    check_eq("reset done", done, 0);
    check_eq("reset dz", dz, 0);
    rst = 1'b0;

    run_cmd(2'd0, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    check_eq("done one cycle", done, 0);
    run_cmd(2'd1, 32'hFFFF_FFFF, 32'd2);
    run_cmd(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_cmd(2'd3, 32'd7, 32'd2);
    run_cmd(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_cmd(2'd3, 32'h0000_1234, 32'd0);
    @(negedge clk);
    check_eq("dz held", dz, 1);
    check_eq("dz done pulse", done, 0);

    // MTLO/MTHI visible the cycle after their edge.
    lo_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk);
    lo_we = 1'b0;
    check_eq("mtlo", lo, 32'hAAAA_5555);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    check_eq("mthi", hi, 32'h1234_5678);

    // Flush mid-divide; the start also ties with an MTLO that must lose.
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd3; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush idle busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("flush no done", seen, 0);
    check_eq("flush lo kept", lo, 32'hAAAA_5555);
    check_eq("flush hi kept", hi, 32'h1234_5678);
    check_eq("flush dz", dz, 0);

    // A start arriving during RUN must not disturb the running divide.
    model(2'd3, 32'd3000, 32'd7, eh, el, ed);
    start = 1'b1; op = 2'd3; a = 32'd3000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd9; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(m);
    n = 6 + m;
    check_eq("ignore start latency", n, 33);
    check_eq("ignore start hi", hi, eh);
    check_eq("ignore start lo", lo, el);
    check_eq("ignore start dz", dz, ed);

    // Synchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'hFFFF_FFFF; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst hi", hi, 0);
    check_eq("midrst lo", lo, 0);
    check_eq("midrst busy", busy, 0);
    check_eq("midrst done", done, 0);
    check_eq("midrst dz", dz, 0);
    rst = 1'b0;
    @(negedge clk);

    // Random back-to-back commands, each accepted in the previous done cycle.
    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom_range(0, 3)), pick(), pick());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
